// File: rtl/axis_block_sig_gen.sv
// Passive AXI-Stream stall watcher. It flags channels whose TVALID has been held without TREADY
// for STALL_THRESH cycles, and it records which channel blocked first and the cycle at which it did.
module axis_block_sig_gen #(
   parameter int NUM_AXIS     = 3,
   parameter int STALL_THRESH = 16,
   parameter int TS_W         = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_AXIS-1:0]   axis_tvalid,
   input  logic [NUM_AXIS-1:0]   axis_tready,
   input  logic                  inst_idle,
   input  logic                  clear_capture,
   output logic [NUM_AXIS-1:0]   axis_block_sigs,
   output logic                  any_block,
   output logic                  first_block_valid,
   output logic [1:0]            first_block_idx,
   output logic [TS_W-1:0]       first_block_ts,
   output logic [2*NUM_AXIS-1:0] fsm_state_dbg
);

   localparam int CNT_W = $clog2(STALL_THRESH + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_BLOCKED = 2'd2
   } state_e;

   state_e              state_q [NUM_AXIS];
   state_e              state_d [NUM_AXIS];
   logic [CNT_W-1:0]    cnt_q   [NUM_AXIS];
   logic [CNT_W-1:0]    cnt_d   [NUM_AXIS];

   logic [NUM_AXIS-1:0] stall;
   logic [NUM_AXIS-1:0] enter_blocked;
   logic                enter_any;
   logic [1:0]          enter_idx;

   logic [NUM_AXIS-1:0] block_q, block_d;
   logic                any_q, any_d;
   logic [TS_W-1:0]     ts_q, ts_d;
   logic                cap_valid_q, cap_valid_d;
   logic [1:0]          cap_idx_q, cap_idx_d;
   logic [TS_W-1:0]     cap_ts_q, cap_ts_d;

   assign stall = axis_tvalid & ~axis_tready & {NUM_AXIS{~inst_idle}};

   // Per-channel stall FSMs; any cycle without the stall condition returns to IDLE.
   always_comb begin
      for (int i = 0; i < NUM_AXIS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_IDLE: begin
               if (stall[i]) begin
                  state_d[i] = ST_WAIT;
                  cnt_d[i]   = CNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (!stall[i]) begin
                  state_d[i] = ST_IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_W'(STALL_THRESH - 1)) begin
                  state_d[i] = ST_BLOCKED;
                  cnt_d[i]   = cnt_q[i] + CNT_W'(1);
               end else begin
                  cnt_d[i]   = cnt_q[i] + CNT_W'(1);
               end
            end
            ST_BLOCKED: begin
               if (!stall[i]) begin
                  state_d[i] = ST_IDLE;
                  cnt_d[i]   = '0;
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // Only a fresh entry into BLOCKED is a capture candidate; the lowest index wins ties.
   always_comb begin
      enter_any = 1'b0;
      enter_idx = 2'd0;
      for (int i = NUM_AXIS - 1; i >= 0; i--) begin
         enter_blocked[i] = (state_d[i] == ST_BLOCKED) && (state_q[i] != ST_BLOCKED);
         block_d[i]       = (state_d[i] == ST_BLOCKED);
         if (enter_blocked[i]) begin
            enter_any = 1'b1;
            enter_idx = 2'(i);
         end
      end
      any_d = |block_d;
   end

   always_comb begin
      ts_d = (ts_q == {TS_W{1'b1}}) ? ts_q : ts_q + TS_W'(1);
   end

   // A new entry beats a coincident clear.
   always_comb begin
      cap_valid_d = cap_valid_q;
      cap_idx_d   = cap_idx_q;
      cap_ts_d    = cap_ts_q;
      if (enter_any && (!cap_valid_q || clear_capture)) begin
         cap_valid_d = 1'b1;
         cap_idx_d   = enter_idx;
         cap_ts_d    = ts_q;
      end else if (clear_capture) begin
         cap_valid_d = 1'b0;
         cap_idx_d   = 2'd0;
         cap_ts_d    = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_AXIS; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
         end
         block_q     <= '0;
         any_q       <= 1'b0;
         ts_q        <= '0;
         cap_valid_q <= 1'b0;
         cap_idx_q   <= 2'd0;
         cap_ts_q    <= '0;
      end else begin
         for (int i = 0; i < NUM_AXIS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         block_q     <= block_d;
         any_q       <= any_d;
         ts_q        <= ts_d;
         cap_valid_q <= cap_valid_d;
         cap_idx_q   <= cap_idx_d;
         cap_ts_q    <= cap_ts_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_AXIS; i++) begin
         fsm_state_dbg[2*i +: 2] = state_q[i];
      end
   end

   assign axis_block_sigs   = block_q;
   assign any_block         = any_q;
   assign first_block_valid = cap_valid_q;
   assign first_block_idx   = cap_idx_q;
   assign first_block_ts    = cap_ts_q;

endmodule

// File: tb/tb_axis_block_sig_gen.sv
// Directed bench for axis_block_sig_gen with STALL_THRESH=4; observed outputs are packed as
// {axis_block_sigs, any_block, first_block_valid, first_block_idx, first_block_ts}.
module tb_axis_block_sig_gen;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  axis_tvalid = '0;
   logic [2:0]  axis_tready = '0;
   logic        inst_idle = 1'b0;
   logic        clear_capture = 1'b0;
   logic [2:0]  axis_block_sigs;
   logic        any_block;
   logic        first_block_valid;
   logic [1:0]  first_block_idx;
   logic [15:0] first_block_ts;
   logic [5:0]  fsm_state_dbg;
   logic [22:0] obs;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] ts_model = '0;
   logic [15:0] ets;

   axis_block_sig_gen #(.NUM_AXIS(3), .STALL_THRESH(4), .TS_W(16)) dut (
      .clock             (clock),
      .reset             (reset),
      .axis_tvalid       (axis_tvalid),
      .axis_tready       (axis_tready),
      .inst_idle         (inst_idle),
      .clear_capture     (clear_capture),
      .axis_block_sigs   (axis_block_sigs),
      .any_block         (any_block),
      .first_block_valid (first_block_valid),
      .first_block_idx   (first_block_idx),
      .first_block_ts    (first_block_ts),
      .fsm_state_dbg     (fsm_state_dbg)
   );

   always #5 clock = ~clock;

   assign obs = {axis_block_sigs, any_block, first_block_valid, first_block_idx, first_block_ts};

   // One clock; ts_model tracks the timestamp value visible during the following cycle.
   task automatic step();
      @(posedge clock);
      ts_model = reset ? 16'd0 : ts_model + 16'd1;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_vec++;
      if (obs !== 23'd0) begin
         $display("FAIL reset_state: got %h expected %h", obs, 23'd0);
         n_err++;
      end
   endtask

   // Stall begins in the first cycle after reset release, so entry happens at timestamp 3.
   task automatic test_single_block();
      axis_tvalid = 3'b010;
      axis_tready = 3'b000;
      for (int k = 0; k < 3; k++) begin
         step();
         n_vec++;
         if (obs !== 23'd0) begin
            $display("FAIL ch1_wait_%0d: got %h expected %h", k, obs, 23'd0);
            n_err++;
         end
      end
      ets = ts_model;
      step();
      n_vec++;
      if (obs !== {3'b010, 1'b1, 1'b1, 2'd1, 16'd3} || ets !== 16'd3) begin
         $display("FAIL ch1_blocked: got %h expected %h", obs, {3'b010, 1'b1, 1'b1, 2'd1, 16'd3});
         n_err++;
      end
      axis_tvalid = 3'b000;
      step();
      n_vec++;
      if (obs !== {3'b000, 1'b0, 1'b1, 2'd1, 16'd3}) begin
         $display("FAIL ch1_release: got %h expected %h", obs, {3'b000, 1'b0, 1'b1, 2'd1, 16'd3});
         n_err++;
      end
   endtask

   task automatic test_short_stall();
      clear_capture = 1'b1;
      step();
      clear_capture = 1'b0;
      n_vec++;
      if (obs !== 23'd0) begin
         $display("FAIL clear_idle: got %h expected %h", obs, 23'd0);
         n_err++;
      end
      axis_tvalid = 3'b001;
      axis_tready = 3'b000;
      repeat (2) step();
      n_vec++;
      if (fsm_state_dbg !== 6'b000001) begin
         $display("FAIL ch0_wait_state: got %b expected %b", fsm_state_dbg, 6'b000001);
         n_err++;
      end
      step();
      axis_tready = 3'b001;
      step();
      n_vec++;
      if (obs !== 23'd0) begin
         $display("FAIL ch0_short_stall: got %h expected %h", obs, 23'd0);
         n_err++;
      end
      axis_tready = 3'b000;
      repeat (3) step();
      n_vec++;
      if (axis_block_sigs !== 3'b000) begin
         $display("FAIL ch0_restall_wait: got %b expected %b", axis_block_sigs, 3'b000);
         n_err++;
      end
      ets = ts_model;
      step();
      n_vec++;
      if (obs !== {3'b001, 1'b1, 1'b1, 2'd0, ets}) begin
         $display("FAIL ch0_restall_block: got %h expected %h", obs, {3'b001, 1'b1, 1'b1, 2'd0, ets});
         n_err++;
      end
      axis_tvalid = 3'b000;
      step();
   endtask

   // ch0 and ch2 block together, then inst_idle drops ch2 while capture stays.
   task automatic test_simultaneous_and_idle();
      clear_capture = 1'b1;
      step();
      clear_capture = 1'b0;
      axis_tvalid = 3'b101;
      axis_tready = 3'b000;
      repeat (3) step();
      ets = ts_model;
      step();
      n_vec++;
      if (obs !== {3'b101, 1'b1, 1'b1, 2'd0, ets}) begin
         $display("FAIL simul_block: got %h expected %h", obs, {3'b101, 1'b1, 1'b1, 2'd0, ets});
         n_err++;
      end
      axis_tvalid = 3'b100;
      step();
      n_vec++;
      if (obs !== {3'b100, 1'b1, 1'b1, 2'd0, ets}) begin
         $display("FAIL ch0_drop: got %h expected %h", obs, {3'b100, 1'b1, 1'b1, 2'd0, ets});
         n_err++;
      end
      inst_idle = 1'b1;
      step();
      inst_idle = 1'b0;
      n_vec++;
      if (obs !== {3'b000, 1'b0, 1'b1, 2'd0, ets}) begin
         $display("FAIL idle_clear: got %h expected %h", obs, {3'b000, 1'b0, 1'b1, 2'd0, ets});
         n_err++;
      end
      axis_tvalid = 3'b000;
      step();
   endtask

   // A channel that is already BLOCKED when the capture is cleared must not re-capture.
   task automatic test_clear_while_blocked();
      axis_tvalid = 3'b100;
      repeat (4) step();
      clear_capture = 1'b1;
      step();
      clear_capture = 1'b0;
      step();
      n_vec++;
      if (obs !== {3'b100, 1'b1, 1'b0, 2'd0, 16'd0}) begin
         $display("FAIL no_recapture: got %h expected %h", obs, {3'b100, 1'b1, 1'b0, 2'd0, 16'd0});
         n_err++;
      end
      axis_tvalid = 3'b000;
      step();
   endtask

   task automatic test_clear_and_capture();
      axis_tvalid = 3'b001;
      repeat (4) step();
      axis_tvalid = 3'b010;
      repeat (3) step();
      ets = ts_model;
      clear_capture = 1'b1;
      step();
      clear_capture = 1'b0;
      n_vec++;
      if (obs !== {3'b010, 1'b1, 1'b1, 2'd1, ets}) begin
         $display("FAIL clear_vs_capture: got %h expected %h", obs, {3'b010, 1'b1, 1'b1, 2'd1, ets});
         n_err++;
      end
      axis_tvalid = 3'b000;
      step();
   endtask

   // Reset mid-WAIT; the stall held across reset must count from scratch (timestamp restarts).
   task automatic test_reset_mid_stall();
      axis_tvalid = 3'b001;
      repeat (2) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_vec++;
      if (obs !== 23'd0) begin
         $display("FAIL reset_mid_stall: got %h expected %h", obs, 23'd0);
         n_err++;
      end
      repeat (3) step();
      n_vec++;
      if (axis_block_sigs !== 3'b000) begin
         $display("FAIL post_reset_wait: got %b expected %b", axis_block_sigs, 3'b000);
         n_err++;
      end
      step();
      n_vec++;
      if (obs !== {3'b001, 1'b1, 1'b1, 2'd0, 16'd3}) begin
         $display("FAIL post_reset_block: got %h expected %h", obs, {3'b001, 1'b1, 1'b1, 2'd0, 16'd3});
         n_err++;
      end
      axis_tvalid = 3'b000;
      step();
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_short_stall();
      test_simultaneous_and_idle();
      test_clear_while_blocked();
      test_clear_and_capture();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axis_block_sig_gen.md
AXIS_BLOCK_SIG_GEN -- requirements
Module: axis_block_sig_gen

Interface
REQ-001 Parameter NUM_AXIS, default 3: number of monitored AXI-Stream channels.
REQ-002 Parameter STALL_THRESH, default 16: consecutive stalled cycles before a channel is declared blocked; legal range 2..65535.
REQ-003 Parameter TS_W, default 16: width of the cycle timestamp.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 axis_tvalid  input  NUM_AXIS  per-channel TVALID, observed only, never driven.
REQ-007 axis_tready  input  NUM_AXIS  per-channel TREADY, observed only, never driven.
REQ-008 inst_idle  input  1  monitored instance idle; suppresses detection.
REQ-009 clear_capture  input  1  single-cycle pulse; clears first-block capture.
REQ-010 axis_block_sigs  output  NUM_AXIS  registered per-channel blocked flags, feeding the deadlock monitor's axis_block_sigs input.
REQ-011 any_block  output  1  registered OR of axis_block_sigs.
REQ-012 first_block_valid  output  1  sticky: a first block has been captured.
REQ-013 first_block_idx  output  2  index of the first channel to block.
REQ-014 first_block_ts  output  TS_W  timestamp at which the first block was captured.

Function
REQ-015 Each channel SHALL run an independent 3-state FSM: IDLE, WAIT, BLOCKED.
REQ-016 Stall condition for channel i: axis_tvalid[i]=1 and axis_tready[i]=0 and inst_idle=0.
REQ-017 IDLE -> WAIT on stall condition; the channel's counter loads 1.
REQ-018 WAIT: counter increments on every stalled cycle; on the cycle the counter equals STALL_THRESH-1 with the stall condition still true, the FSM enters BLOCKED.
REQ-019 axis_block_sigs[i] SHALL be 1 exactly while the FSM is in BLOCKED; it rises 1 cycle after the STALL_THRESH-th consecutive stalled cycle.
REQ-020 WAIT or BLOCKED -> IDLE on any cycle without the stall condition (handshake, TVALID drop, or inst_idle=1); the counter clears; axis_block_sigs[i] falls the following cycle.
REQ-021 Counter width: ceil(log2(STALL_THRESH+1)); the counter holds (never wraps) while BLOCKED.
REQ-022 Timestamp counter: TS_W bits, increments every cycle from 0 after reset, saturates at all-ones, never wraps.
REQ-023 Capture: while first_block_valid=0, the first cycle any FSM enters BLOCKED sets first_block_valid=1, first_block_idx=that channel, first_block_ts=current timestamp.
REQ-024 Simultaneous entries into BLOCKED: the lowest channel index is captured.
REQ-025 Capture holds while first_block_valid=1 until clear_capture; a clear with no new BLOCKED entry zeroes all three capture outputs next cycle.
REQ-026 clear_capture coincident with a new BLOCKED entry: the new entry is captured (capture wins over clear).
REQ-027 Channels already BLOCKED at clear time SHALL NOT re-capture until they leave and re-enter BLOCKED.
REQ-028 any_block SHALL equal the registered OR of the per-channel BLOCKED states, with the same timing as axis_block_sigs.
REQ-029 The block SHALL be purely observational: no combinational path from any input to any output.

Reset
REQ-030 reset=1 SHALL force all FSMs to IDLE and zero all counters, the timestamp and every output on the next edge; reset mid-stall discards partial counts.
REQ-031 After reset deassertion, a stall beginning in the first cycle SHALL follow REQ-017..019 timing.

Verification (STALL_THRESH=4)
REQ-032 ch1 TVALID=1, TREADY=0 for 4 cycles starting at t0 -> axis_block_sigs=3'b010 and any_block=1 from t0+4; first_block_idx=1, first_block_ts=timestamp at entry.
REQ-033 ch0 stalled for 3 cycles, then handshake -> axis_block_sigs stays 0; a fresh 4-cycle stall then blocks normally.
REQ-034 ch0 and ch2 stall starting the same cycle -> both bits set together; first_block_idx=0.
REQ-035 ch2 BLOCKED; inst_idle=1 for one cycle -> bit 2 clears next cycle; capture retained.
REQ-036 clear_capture pulsed in the same cycle ch1 enters BLOCKED -> first_block_valid=1, first_block_idx=1.
REQ-037 reset asserted during ch0 WAIT with count 2 -> all outputs 0; a later stall needs a full 4 cycles to block.
